aes_ahb_master: RTL and testbench
=================================

Name: aes_ahb_master

Overview:
AHB-lite-style bus initiator that drives the aes_core register map on behalf of on-chip logic. It accepts a 128-bit key and 128-bit plaintext through a valid/ready request port, then writes KEY0-3, TEXT0-3 and CTRL. It waits for the done indication on HRESP, reads CIPHER0-3, and returns the 128-bit ciphertext through a valid/ready response port. It replaces bench-driven bus sequencing when aes_core is integrated into a subsystem.

Parameters:
BASE_ADDR, 32'h0000_0000, base address of aes_core; all offsets are added to it.
TIMEOUT_CYCLES, 256, maximum cycles spent in WAIT before aborting with an error; must be at least 1.

Ports:
HCLK  in  1  clock; all state changes on the rising edge
HRESETn  in  1  asynchronous, active-low reset
req_valid  in  1  key and plaintext are valid
req_ready  out  1  block can accept a request (high only in IDLE)
req_key  in  128  AES key; KEY0 = req_key[31:0] ... KEY3 = req_key[127:96]
req_text  in  128  plaintext; TEXT0 = [31:0] ... TEXT3 = [127:96]
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts the response
rsp_cipher  out  128  ciphertext; CIPHER0 -> [31:0] ... CIPHER3 -> [127:96]
rsp_err  out  1  the request timed out waiting for done
HSEL  out  1  slave select
HADDR  out  32  byte address
HWRITE  out  1  1 = write, 0 = read
HREADY  out  1  driven to 1 whenever not in reset
HWDATA  out  32  write data
HRDATA  in  32  read data from aes_core
HRESP  in  1  aes_core done flag (1 = ciphertext ready)

Behaviour:
- Reset (asynchronous, HRESETn=0): state IDLE; counters 0; HSEL=0, HWRITE=0, HADDR=0, HWDATA=0, HREADY=0; rsp_valid=0, rsp_err=0, rsp_cipher=0; req_ready=0 while in reset, 1 after release. Reset mid-transaction aborts immediately; the bus returns to idle values.
- Register offsets: KEY0-3 at 0x00, 0x04, 0x08, 0x0C. TEXT0-3 at 0x10-0x1C. CTRL at 0x20. CIPHER0-3 at 0x24, 0x28, 0x2C, 0x30.
- Transfer timing: each bus transfer takes 2 cycles.
  - Cycle A: HSEL=1, HADDR, HWRITE and HWDATA are registered outputs.
  - Cycle B: HSEL=0, HWRITE=0, HADDR=0, HWDATA=0.
  - For reads, HRDATA is captured at the rising edge that ends cycle B.
- FSM states: IDLE, WRITE, WAIT, READ, RESP.
  - IDLE: req_ready=1. On req_valid, latch key and text into internal registers, set wr_idx=0, go to WRITE. Inputs are ignored outside IDLE.
  - WRITE: 9 transfers in order KEY0..KEY3, TEXT0..TEXT3, then CTRL with data 32'h1. wr_idx counts 0..8; after the 9th cycle B, go to WAIT. Length is 18 cycles.
  - WAIT: bus idle; HRESP is sampled every cycle and a wait counter increments.
    - HRESP=1: go to READ with rd_idx=0. HRESP=1 on the first WAIT cycle is valid.
    - Counter reaches TIMEOUT_CYCLES with no HRESP: go to RESP with rsp_err=1 and rsp_cipher=0; READ is skipped.
    - If HRESP and the timeout hit in the same cycle, HRESP wins.
  - READ: 4 read transfers CIPHER0..CIPHER3; each captured word goes into rsp_cipher[32*rd_idx +: 32]. After the 4th cycle B, go to RESP with rsp_err=0. Length is 8 cycles.
  - RESP: rsp_valid=1; rsp_cipher and rsp_err are held stable until rsp_ready=1. On that edge, clear rsp_valid and go to IDLE. The next request can be accepted no earlier than the following cycle.
- Latency: at least 1 cycle from request acceptance to first HSEL. Best case, acceptance to rsp_valid is 1 + 18 + 1 + 8 = 28 cycles.
- Address arithmetic: HADDR = BASE_ADDR + offset, modulo 2^32 (wraps silently).
- HRDATA and HRESP are ignored in IDLE and RESP.

Decomposition:
- Shared package aes_ahb_pkg:
  - offset constants KEY_OFS, TEXT_OFS, CTRL_OFS, CIPHER_OFS
  - CTRL_START = 32'h1
  - state encoding typedef (IDLE, WRITE, WAIT, READ, RESP)
  - the aes_core testbench reuses these offsets
- One natural sub-module, aes_ahb_xfer: a 2-cycle single-transfer sequencer with start, write, addr and wdata inputs, done and rdata outputs. The top FSM sequences the address and data lists through it.

Test Plan:
- FIPS-197 vector: key 2b7e151628aed2a6abf7158809cf4f3c, text 3243f6a8885a308d313198a2e0370734, slave model asserts HRESP 10 cycles after CTRL=1 -> 9 writes observed in order (KEY0=09cf4f3c ... TEXT3=3243f6a8, CTRL=1); rsp_cipher=3925841d02dc09fbdc118597196a0b32, rsp_err=0.
- HRESP already high when WAIT is entered -> READ starts on the next cycle; request accepted to rsp_valid in exactly 28 cycles.
- HRESP never asserted with TIMEOUT_CYCLES=16 -> no read transfers; rsp_valid with rsp_err=1 and rsp_cipher=0 after exactly 16 WAIT cycles.
- Backpressure: rsp_ready held low for 20 cycles and req_valid held high -> response stable, req_ready=0, no bus activity; after rsp_ready, the next request starts.
- Reset pulse during the 3rd write (KEY2) -> outputs go to their reset values immediately; after release, a fresh request completes correctly from KEY0.
- BASE_ADDR=32'hFFFF_FFF0 -> CTRL written at 32'h0000_0010 (wrap); addresses match the modulo-2^32 rule.

Source files
------------

// File: rtl/aes_ahb_pkg.sv
// Register map, sequencing constants and state types shared by the aes_core bus initiator
// and the aes_core benches.
package aes_ahb_pkg;
    localparam logic [31:0] KEY_OFS    = 32'h00;
    localparam logic [31:0] TEXT_OFS   = 32'h10;
    localparam logic [31:0] CTRL_OFS   = 32'h20;
    localparam logic [31:0] CIPHER_OFS = 32'h24;
    localparam logic [31:0] CTRL_START = 32'h1;
    localparam logic [3:0]  WR_LAST    = 4'd8;
    localparam logic [1:0]  RD_LAST    = 2'd3;

    typedef enum logic [2:0] {IDLE, WRITE, WAIT, READ, RESP} state_e;
    typedef enum logic [1:0] {PH_IDLE, PH_A, PH_B} xfer_ph_e;

    // Write list order: KEY0-3, TEXT0-3, then CTRL.
    function automatic logic [31:0] wr_ofs(input logic [3:0] idx);
        if (idx == WR_LAST) return CTRL_OFS;
        return (idx[2] ? TEXT_OFS : KEY_OFS) + {28'd0, idx[1:0], 2'b00};
    endfunction

    function automatic logic [31:0] rd_ofs(input logic [1:0] idx);
        return CIPHER_OFS + {28'd0, idx, 2'b00};
    endfunction
endpackage

// File: rtl/aes_ahb_xfer.sv
// Two-cycle single bus transfer: cycle A drives the registered address phase,
// cycle B returns the bus to idle and HRDATA is taken at the edge ending it.
module aes_ahb_xfer
    import aes_ahb_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] hrdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        hsel_o,
    output logic [31:0] haddr_o,
    output logic        hwrite_o,
    output logic [31:0] hwdata_o
);
    xfer_ph_e    ph_q, ph_d;
    logic        hsel_q, hsel_d, hwrite_q, hwrite_d;
    logic [31:0] haddr_q, haddr_d, hwdata_q, hwdata_d;

    // A new start may coincide with cycle B so transfers run back to back.
    always_comb begin
        ph_d     = ph_q;
        hsel_d   = 1'b0;
        hwrite_d = 1'b0;
        haddr_d  = '0;
        hwdata_d = '0;
        if (start_i && ph_q != PH_A) begin
            ph_d     = PH_A;
            hsel_d   = 1'b1;
            hwrite_d = write_i;
            haddr_d  = addr_i;
            hwdata_d = write_i ? wdata_i : '0;
        end else if (ph_q == PH_A) begin
            ph_d = PH_B;
        end else if (ph_q == PH_B) begin
            ph_d = PH_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ph_q     <= PH_IDLE;
            hsel_q   <= 1'b0;
            hwrite_q <= 1'b0;
            haddr_q  <= '0;
            hwdata_q <= '0;
        end else begin
            ph_q     <= ph_d;
            hsel_q   <= hsel_d;
            hwrite_q <= hwrite_d;
            haddr_q  <= haddr_d;
            hwdata_q <= hwdata_d;
        end
    end

    assign busy_o   = (ph_q != PH_IDLE);
    assign done_o   = (ph_q == PH_B);
    assign rdata_o  = hrdata_i;
    assign hsel_o   = hsel_q;
    assign haddr_o  = haddr_q;
    assign hwrite_o = hwrite_q;
    assign hwdata_o = hwdata_q;
endmodule

// File: rtl/aes_ahb_master.sv
// Bus initiator for aes_core: loads key/text, starts the core, polls done on HRESP,
// reads the ciphertext back and hands it out on a valid/ready response port.
module aes_ahb_master
    import aes_ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic         HCLK,
    input  logic         HRESETn,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [127:0] req_key,
    input  logic [127:0] req_text,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_cipher,
    output logic         rsp_err,
    output logic         HSEL,
    output logic [31:0]  HADDR,
    output logic         HWRITE,
    output logic         HREADY,
    output logic [31:0]  HWDATA,
    input  logic [31:0]  HRDATA,
    input  logic         HRESP
);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_e       state_q, state_d;
    logic [3:0]   wr_idx_q, wr_idx_d, wr_sel;
    logic [1:0]   rd_idx_q, rd_idx_d;
    logic [31:0]  wait_q, wait_d;
    logic [127:0] key_q, key_d, text_q, text_d, cipher_q, cipher_d;
    logic         err_q, err_d;
    logic         x_start, x_write, x_busy, x_done;
    logic [31:0]  x_ofs, x_wdata, x_rdata;

    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        wait_d   = wait_q;
        key_d    = key_q;
        text_d   = text_q;
        cipher_d = cipher_q;
        err_d    = err_q;
        x_start  = 1'b0;
        x_write  = 1'b0;
        x_ofs    = '0;
        x_wdata  = '0;
        // First write issues from an idle sequencer, the rest chain off done.
        wr_sel   = x_busy ? wr_idx_q + 4'd1 : wr_idx_q;
        unique case (state_q)
            IDLE: if (req_valid) begin
                key_d    = req_key;
                text_d   = req_text;
                wr_idx_d = '0;
                cipher_d = '0;
                err_d    = 1'b0;
                state_d  = WRITE;
            end
            WRITE: begin
                x_write = 1'b1;
                x_ofs   = wr_ofs(wr_sel);
                if (wr_sel == WR_LAST)  x_wdata = CTRL_START;
                else if (wr_sel[2])     x_wdata = text_q[32*wr_sel[1:0] +: 32];
                else                    x_wdata = key_q[32*wr_sel[1:0] +: 32];
                if (!x_busy) begin
                    x_start = 1'b1;
                end else if (x_done) begin
                    if (wr_idx_q == WR_LAST) begin
                        wait_d  = '0;
                        state_d = WAIT;
                    end else begin
                        wr_idx_d = wr_sel;
                        x_start  = 1'b1;
                    end
                end
            end
            WAIT: begin
                wait_d = wait_q + 32'd1;
                if (HRESP) begin
                    rd_idx_d = '0;
                    x_start  = 1'b1;
                    x_ofs    = rd_ofs(2'd0);
                    state_d  = READ;
                end else if (wait_q == TO_LAST) begin
                    err_d    = 1'b1;
                    cipher_d = '0;
                    state_d  = RESP;
                end
            end
            READ: if (x_done) begin
                cipher_d[32*rd_idx_q +: 32] = x_rdata;
                if (rd_idx_q == RD_LAST) begin
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    rd_idx_d = rd_idx_q + 2'd1;
                    x_start  = 1'b1;
                    x_ofs    = rd_ofs(rd_idx_d);
                end
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= IDLE;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            wait_q   <= '0;
            key_q    <= '0;
            text_q   <= '0;
            cipher_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            wait_q   <= wait_d;
            key_q    <= key_d;
            text_q   <= text_d;
            cipher_q <= cipher_d;
            err_q    <= err_d;
        end
    end

    aes_ahb_xfer u_xfer (
        .clk_i    (HCLK),
        .rst_ni   (HRESETn),
        .start_i  (x_start),
        .write_i  (x_write),
        .addr_i   (BASE_ADDR + x_ofs),
        .wdata_i  (x_wdata),
        .hrdata_i (HRDATA),
        .busy_o   (x_busy),
        .done_o   (x_done),
        .rdata_o  (x_rdata),
        .hsel_o   (HSEL),
        .haddr_o  (HADDR),
        .hwrite_o (HWRITE),
        .hwdata_o (HWDATA)
    );

    assign HREADY     = HRESETn;
    assign req_ready  = HRESETn && (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign rsp_cipher = cipher_q;
    assign rsp_err    = err_q;
endmodule

// File: tb/tb_aes_ahb_master.sv
// Bench for aes_ahb_master: slave model with programmable done delay, vector table plus
// random rows checked against a transfer-list/latency model, and backpressure/reset sequences.
module tb_aes_ahb_master;
    localparam logic [31:0] BASE = 32'hFFFF_FFF0;
    localparam int          TO   = 16;

    typedef struct {
        logic [127:0] key, text, cipher;
        int           delay;
        bit           exp_err;
        int           exp_lat;
    } vec_t;
    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    logic         HCLK = 0, HRESETn = 0;
    logic         req_valid = 0, rsp_ready = 0, req_ready, rsp_valid, rsp_err;
    logic [127:0] req_key = '0, req_text = '0, rsp_cipher;
    logic         HSEL, HWRITE, HREADY, HRESP;
    logic [31:0]  HADDR, HWDATA, HRDATA;

    int errors = 0, checks = 0;
    xfer_t        xlog[$];
    int           log_base = 0, bviol = 0, bviol_base = 0;
    logic         prev_hsel = 0, ctrl_seen = 0;
    int           cnt = 0, resp_delay = 0, k;
    logic [31:0]  rd_ofs = '0;
    logic [127:0] slv_cipher = '0;
    vec_t         tbl[12];

    aes_ahb_master #(.BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .req_text(req_text), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_cipher(rsp_cipher), .rsp_err(rsp_err), .HSEL(HSEL), .HADDR(HADDR),
        .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(HRDATA), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    // Slave and bus monitor, sampled mid-cycle.
    always @(negedge HCLK) begin
        if (HSEL) xlog.push_back('{HWRITE, HADDR, HWDATA});
        if (prev_hsel && (HSEL || HWRITE || HADDR != 0 || HWDATA != 0)) bviol <= bviol + 1;
        prev_hsel <= HSEL;
        if (HSEL && !HWRITE) rd_ofs <= HADDR - BASE;
        if (req_valid && req_ready) ctrl_seen <= 1'b0;
        else if (HSEL && HWRITE && HADDR == BASE + 32'h20) begin
            ctrl_seen <= 1'b1;
            cnt       <= 0;
        end else cnt <= cnt + 1;
    end
    assign HRESP = ctrl_seen && (cnt > resp_delay);
    always_comb begin
        k      = int'((rd_ofs - 32'h24) >> 2);
        HRDATA = 32'hDEAD_BEEF;
        if (rd_ofs >= 32'h24 && rd_ofs <= 32'h30) HRDATA = slv_cipher[32*k +: 32];
    end

    // Reference model: done seen on WAIT cycle max(delay,1); abort after TO cycles.
    function automatic int eff_wait(input int d);
        return (d < 1) ? 1 : d;
    endfunction
    function automatic bit m_err(input int d);
        return eff_wait(d) > TO;
    endfunction
    function automatic int m_lat(input int d);
        return m_err(d) ? 1 + 18 + TO : 1 + 18 + eff_wait(d) + 8;
    endfunction
    function automatic xfer_t exp_xfer(input vec_t v, input int i);
        xfer_t e;
        if (i < 9) begin
            e.wr   = 1'b1;
            e.addr = BASE + ((i < 8) ? 32'(4 * i) : 32'h20);
            e.data = (i < 4) ? v.key[32*i +: 32] : (i < 8) ? v.text[32*(i-4) +: 32] : 32'h1;
        end else begin
            e.wr   = 1'b0;
            e.addr = BASE + 32'h24 + 32'(4 * (i - 9));
            e.data = '0;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input vec_t v);
        int n = 0;
        resp_delay = v.delay;
        slv_cipher = v.cipher;
        req_key    = v.key;
        req_text   = v.text;
        req_valid  = 1'b1;
        while (!req_ready && n < 50) begin @(posedge HCLK); #1; n++; end
        chk("req_ready before accept", req_ready, 1);
        @(posedge HCLK); #1;
        req_valid  = 1'b0;
        log_base   = xlog.size();
        bviol_base = bviol;
    endtask

    task automatic collect(input vec_t v, input int bp, input bit has_nxt, input vec_t nxt);
        int n = 0, nexp;
        logic [127:0] ecip;
        xfer_t e;
        while (!rsp_valid && n < 200) begin @(posedge HCLK); #1; n++; end
        chk("latency", n, v.exp_lat);
        ecip = v.exp_err ? '0 : v.cipher;
        chk("rsp_err", rsp_err, v.exp_err);
        chk("rsp_cipher", rsp_cipher, ecip);
        nexp = v.exp_err ? 9 : 13;
        chk("xfer count", xlog.size() - log_base, nexp);
        for (int i = 0; i < nexp && log_base + i < xlog.size(); i++) begin
            e = exp_xfer(v, i);
            chk($sformatf("xfer%0d addr", i), xlog[log_base+i].addr, e.addr);
            chk($sformatf("xfer%0d dir", i), xlog[log_base+i].wr, e.wr);
            if (e.wr) chk($sformatf("xfer%0d data", i), xlog[log_base+i].data, e.data);
        end
        chk("cycle B idle", bviol - bviol_base, 0);
        for (int c = 0; c < bp; c++) begin
            if (has_nxt) begin
                req_key = nxt.key; req_text = nxt.text; req_valid = 1'b1;
            end
            @(posedge HCLK); #1;
            chk("bp rsp_valid", rsp_valid, 1);
            chk("bp cipher stable", rsp_cipher, ecip);
            chk("bp err stable", rsp_err, v.exp_err);
            chk("bp req_ready", req_ready, 0);
            chk("bp hsel", HSEL, 0);
        end
        rsp_ready = 1'b1;
        @(posedge HCLK); #1;
        rsp_ready = 1'b0;
        chk("rsp_valid cleared", rsp_valid, 0);
        if (!has_nxt) chk("req_ready after rsp", req_ready, 1);
    endtask

    task automatic chk_reset_vals();
        chk("rst HSEL", HSEL, 0);
        chk("rst HADDR", HADDR, 0);
        chk("rst HWRITE", HWRITE, 0);
        chk("rst HWDATA", HWDATA, 0);
        chk("rst HREADY", HREADY, 0);
        chk("rst req_ready", req_ready, 0);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst rsp_err", rsp_err, 0);
        chk("rst rsp_cipher", rsp_cipher, 0);
    endtask

    initial begin
        int n;
        tbl[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                   128'h3925841d02dc09fbdc118597196a0b32, 10, 1'b0, 37};
        tbl[1] = '{{4{32'h0123_4567}}, {4{32'h89ab_cdef}}, {4{32'h5a5a_a5a5}}, 0, 1'b0, 28};
        tbl[2] = '{{4{32'hffff_ffff}}, '0, {4{32'hc001_d00d}}, 1, 1'b0, 28};
        tbl[3] = '{'0, {4{32'hffff_ffff}}, {4{32'h1357_9bdf}}, 16, 1'b0, 43};
        tbl[4] = '{{4{32'h1111_2222}}, {4{32'h3333_4444}}, {4{32'h7777_8888}}, 17, 1'b1, 35};
        tbl[5] = '{{4{32'h0f0f_0f0f}}, {4{32'hf0f0_f0f0}}, {4{32'h9999_9999}}, 1000, 1'b1, 35};
        for (int i = 6; i < 12; i++) begin
            tbl[i].key    = {$urandom, $urandom, $urandom, $urandom};
            tbl[i].text   = {$urandom, $urandom, $urandom, $urandom};
            tbl[i].cipher = {$urandom, $urandom, $urandom, $urandom};
            tbl[i].delay  = $urandom_range(0, 20);
            tbl[i].exp_err = m_err(tbl[i].delay);
            tbl[i].exp_lat = m_lat(tbl[i].delay);
        end

        repeat (2) @(posedge HCLK);
        #1;
        chk_reset_vals();
        HRESETn = 1'b1;
        #1;
        chk("req_ready after release", req_ready, 1);
        chk("HREADY after release", HREADY, 1);

        for (int i = 0; i < 12; i++) begin
            issue(tbl[i]);
            collect(tbl[i], 0, 1'b0, tbl[i]);
        end

        // Held response with a pending request behind it.
        issue(tbl[6]);
        collect(tbl[6], 20, 1'b1, tbl[1]);
        issue(tbl[1]);
        collect(tbl[1], 0, 1'b0, tbl[1]);

        // Reset during KEY2, then a clean request.
        issue(tbl[2]);
        n = 0;
        while (!(HSEL && HADDR == BASE + 32'h8) && n < 60) begin @(posedge HCLK); #1; n++; end
        chk("reached KEY2", HADDR, BASE + 32'h8);
        HRESETn = 1'b0;
        #1;
        chk_reset_vals();
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        #1;
        chk("req_ready after mid reset", req_ready, 1);
        issue(tbl[0]);
        collect(tbl[0], 0, 1'b0, tbl[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
